// File: rtl/regfile_dump_unit_if.sv
// Byte-stream link between the register dump reader and the TX/debug sink.
// master drives data/valid, slave returns ready.
interface regfile_dump_unit_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/regfile_dump_unit.sv
// Walks x0..x(NUM_REGS-1) over the regfile debug read port and streams each word
// as bytes over a valid/ready link. Optional trailing XOR byte: DUMP_CHECKSUM_EN.
module regfile_dump_unit #(
    parameter int unsigned NUM_REGS  = 32,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic [4:0]           rs_dbg_addr_o,
    input  logic [31:0]          rs_dbg_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    regfile_dump_unit_if.master  tx
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state, state_nxt;
    logic [4:0]  idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic [1:0]  byte_sel;
    logic [7:0]  cur_byte;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // MSB-first order is just the byte counter reversed
    assign byte_sel = LSB_FIRST ? byte_cnt : ~byte_cnt;
    assign cur_byte = word[{byte_sel, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start_i) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = abort_i ? IDLE : SEND;
            end
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx.tx_ready_i) begin
                    if (abort_i) begin
                        state_nxt = IDLE;
                    end else if (byte_cnt == 2'd3) begin
`ifdef DUMP_CHECKSUM_EN
                        state_nxt = (idx == LAST_IDX) ? CSUM : LOAD;
`else
                        state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx.tx_ready_i) state_nxt = abort_i ? IDLE : DONE;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            byte_cnt <= '0;
            word     <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    idx      <= '0;
                    byte_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
                    if (start_i) csum <= '0;
`endif
                end
                LOAD: begin
                    if (abort_i) begin
                        idx      <= '0;
                        byte_cnt <= '0;
                    end else begin
                        word <= rs_dbg_data_i;
                    end
                end
                SEND: begin
                    if (tx.tx_ready_i) begin
`ifdef DUMP_CHECKSUM_EN
                        csum <= csum ^ cur_byte;
`endif
                        if (abort_i) begin
                            idx      <= '0;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3 && idx != LAST_IDX) idx <= idx + 5'd1;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (tx.tx_ready_i && abort_i) begin
                        idx      <= '0;
                        byte_cnt <= '0;
                    end
                end
`endif
                DONE: begin
                    idx      <= '0;
                    byte_cnt <= '0;
                end
                default: begin
                    idx      <= '0;
                    byte_cnt <= '0;
                end
            endcase
        end
    end

    assign rs_dbg_addr_o = idx;
    assign tx.tx_data_o  = tx_data;
    assign tx.tx_valid_o = tx_valid;
    assign busy_o        = busy;
    assign done_o        = done;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Randomized bench for regfile_dump_unit: regfile array model, byte-stream
// reference built from register snapshots, ready stalls, abort and reset cases.
module tb_regfile_dump_unit;

    localparam int unsigned NR   = 32;
    localparam bit          LSBF = 1'b1;
`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    logic [31:0] regs [NR];
    logic [31:0] snap [NR];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    regfile_dump_unit_if tx_if ();

    regfile_dump_unit #(.NUM_REGS(NR), .LSB_FIRST(LSBF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .rs_dbg_addr_o (addr),
        .rs_dbg_data_i (rdata),
        .busy_o        (busy),
        .done_o        (done),
        .tx            (tx_if.master)
    );

    assign rdata = regs[addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, so the negedge view equals what the next posedge sees.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev)
                check("hold", {23'd0, tx_if.tx_valid_o, tx_if.tx_data_o}, {23'd0, 1'b1, stall_data});
            if (tx_if.tx_valid_o && tx_if.tx_ready_i) rx_q.push_back(tx_if.tx_data_o);
            stall_prev = tx_if.tx_valid_o && !tx_if.tx_ready_i;
            stall_data = tx_if.tx_data_o;
            if (done) done_cnt++;
            if (busy) busy_cyc++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic void build_exp();
        logic [7:0] b;
        logic [7:0] x;
        int unsigned sh;
        x = '0;
        exp_q.delete();
        for (int unsigned r = 0; r < NR; r++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                sh = LSBF ? 8 * k : 8 * (3 - k);
                b  = 8'((snap[r] >> sh) & 32'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        if (EXTRA != 0) exp_q.push_back(x);
    endfunction

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    endtask

    // mode 0: ready always 1; 1: random ready; 2: ready=1 with one 10-cycle stall mid-word
    task automatic run_dump(input string tag, input int mode, input bit poke_start, input bit overwrite_x1);
        int cyc;
        int stall_left;
        bit stall_used;
        bit wrote;
        for (int unsigned r = 0; r < NR; r++) snap[r] = regs[r];
        build_exp();
        rx_q.delete();
        done_cnt = 0;
        busy_cyc = 0;
        stall_left = 0;
        stall_used = 1'b0;
        wrote = 1'b0;
        tx_if.tx_ready_i = (mode != 1) ? 1'b1 : 1'b0;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            if (mode == 0 && cyc == 0) begin
                check({tag, "_lat_busy"}, busy, 1);
                check({tag, "_lat_valid0"}, tx_if.tx_valid_o, 0);
                check({tag, "_lat_addr"}, addr, 0);
            end
            if (mode == 0 && cyc == 1) begin
                check({tag, "_lat_valid1"}, tx_if.tx_valid_o, 1);
                check({tag, "_lat_byte0"}, tx_if.tx_data_o, exp_q[0]);
            end
            case (mode)
                0: tx_if.tx_ready_i = 1'b1;
                1: tx_if.tx_ready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_left > 0) begin
                        tx_if.tx_ready_i = 1'b0;
                        stall_left--;
                    end else if (!stall_used && rx_q.size() == 14) begin
                        stall_used = 1'b1;
                        stall_left = 9;
                        tx_if.tx_ready_i = 1'b0;
                    end else begin
                        tx_if.tx_ready_i = 1'b1;
                    end
                end
            endcase
            start_i = (poke_start && (cyc == 20 || cyc == 90));
            if (overwrite_x1 && !wrote && addr == 5'd1 && tx_if.tx_valid_o) begin
                regs[1] = 32'h12345678;
                wrote = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        check({tag, "_timeout"}, (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_addr"}, addr, 0);
        if (mode == 0) check({tag, "_cycles"}, busy_cyc, 5 * NR + EXTRA);
        if (overwrite_x1) check({tag, "_wrote"}, wrote, 1);
        compare_stream(tag);
    endtask

    initial begin
        int cyc;
        for (int unsigned r = 0; r < NR; r++) regs[r] = '0;
        rst_n = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        tx_if.tx_ready_i = 1'b0;

        #12;
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", tx_if.tx_valid_o, 0);
        check("rst_data", tx_if.tx_data_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", tx_if.tx_valid_o, 0);

        regs[1] = 32'hDEADBEEF;
        regs[2] = 32'hCAFEBABE;
        run_dump("basic", 0, 1'b0, 1'b0);
        if (LSBF) begin
            check("basic_x1_b0", rx_q[4], 8'hEF);
            check("basic_x1_b3", rx_q[7], 8'hDE);
            check("basic_x2_b3", rx_q[11], 8'hCA);
        end
`ifdef DUMP_CHECKSUM_EN
        check("basic_csum", rx_q[rx_q.size() - 1], 8'h12);
`endif

        run_dump("stall", 2, 1'b0, 1'b0);
        run_dump("poke", 0, 1'b1, 1'b0);
        run_dump("overwr", 1, 1'b0, 1'b1);
        run_dump("newval", 1, 1'b0, 1'b0);
        if (LSBF) check("newval_x1_b0", rx_q[4], 8'h78);

        for (int it = 0; it < 3; it++) begin
            for (int unsigned r = 1; r < NR; r++) regs[r] = $urandom;
            run_dump($sformatf("rnd%0d", it), 1, 1'b0, 1'b0);
        end

        // reset while byte 2 of x5 is on the link
        tx_if.tx_ready_i = 1'b1;
        rx_q.delete();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 0;
        while (rx_q.size() != 22 && cyc < 400) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("rstmid_reach", rx_q.size(), 22);
        check("rstmid_addr", addr, 5);
        rst_n = 1'b0;
        #1;
        check("rstmid_addr0", addr, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", tx_if.tx_valid_o, 0);
        check("rstmid_data", tx_if.tx_data_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_dump("after_rst", 0, 1'b0, 1'b0);

        // abort ignored without handshake, honoured on a handshake
        rx_q.delete();
        done_cnt = 0;
        tx_if.tx_ready_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 0;
        while (!(addr == 5'd2 && tx_if.tx_valid_o) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        tx_if.tx_ready_i = 1'b0;
        abort_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_stall_busy", busy, 1);
            check("abort_stall_valid", tx_if.tx_valid_o, 1);
        end
        abort_i = 1'b0;
        tx_if.tx_ready_i = 1'b1;
        cyc = 0;
        while (!(addr == 5'd3 && tx_if.tx_valid_o) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", tx_if.tx_valid_o, 0);
        check("abort_addr", addr, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_nodone", done_cnt, 0);
        check("abort_bytes", rx_q.size(), 13);
        run_dump("after_abort", 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
